// File: rtl/c880_trojan_pkg.sv
// Shared constants, FSM state type and helpers for the c880 response compactor.
package c880_trojan_pkg;

  localparam int RESP_W = 26;
  localparam int SIG_W  = 32;

  // x^32 + x^22 + x^2 + x + 1, the x^32 term is implicit in the shift-out
  localparam logic [SIG_W-1:0] POLY = 32'h0040_0007;
  localparam logic [SIG_W-1:0] SEED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of set bits in one response word (0..26 fits in 5 bits)
  function automatic logic [4:0] popcount_resp(input logic [RESP_W-1:0] r);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < RESP_W; i++) begin
      cnt = cnt + 5'(r[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/c880_response_compactor_misr32.sv
// 32-bit multiple-input signature register: Galois-style shift with
// polynomial feedback, parallel data XORed into every beat.
module misr32
  import c880_trojan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] seed,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  // Load has priority so a session restart always begins from the seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/c880_response_compactor.sv
// Compacts c880 primary-output responses into a MISR signature, tracks
// response-to-response switching activity, and flags a golden mismatch.
module c880_response_compactor
  import c880_trojan_pkg::*;
#(
  parameter int HD_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       pattern_count,
  input  logic [SIG_W-1:0]  golden_sig,
  input  logic              resp_valid,
  output logic              resp_ready,
  input  logic [RESP_W-1:0] resp_data,
  output logic [SIG_W-1:0]  sig,
  output logic [HD_W-1:0]   hd_accum,
  output logic [15:0]       patterns_done,
  output logic              busy,
  output logic              done,
  output logic              mismatch
);

  localparam logic [31:0] HD_MAX = 32'((64'd1 << HD_W) - 64'd1);

  state_t            state;
  logic [RESP_W-1:0] prev_resp;
  logic [15:0]       count_reg;
  logic              start_ok;
  logic              beat;
  logic [31:0]       hd_sum;
  logic [HD_W-1:0]   hd_next;
  logic [15:0]       done_next;

  // Abort suppresses both a new session and a coincident beat
  assign start_ok   = start && !abort && (state == IDLE || state == DONE);
  assign resp_ready = (state == RUN);
  assign beat       = resp_valid && resp_ready && !abort;

  assign hd_sum    = 32'(hd_accum) + 32'(popcount_resp(resp_data ^ prev_resp));
  assign hd_next   = (hd_sum > HD_MAX) ? HD_MAX[HD_W-1:0] : hd_sum[HD_W-1:0];
  assign done_next = patterns_done + 16'd1;

  misr32 u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start_ok),
    .en   (beat),
    .seed (SEED),
    .din  ({{(SIG_W-RESP_W){1'b0}}, resp_data}),
    .sig  (sig)
  );

  // Session FSM with counters, HD accumulator and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hd_accum      <= '0;
      patterns_done <= '0;
      prev_resp     <= '0;
      count_reg     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch      <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            count_reg     <= pattern_count;
            hd_accum      <= '0;
            patterns_done <= '0;
            prev_resp     <= '0;
            mismatch      <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            state         <= (pattern_count == 16'd0) ? FINAL : RUN;
          end
        end
        RUN: begin
          if (beat) begin
            hd_accum      <= hd_next;
            prev_resp     <= resp_data;
            patterns_done <= done_next;
            if (done_next == count_reg) begin
              state <= FINAL;
            end
          end
        end
        FINAL: begin
          mismatch <= (sig != golden_sig);
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
